pipelined_adder: RTL and testbench

- Parametrised N-bit adder with the carry chain split into CHUNK-bit slices and a register after each slice. This gives a STAGES-deep pipeline that accepts one operation per cycle.
- Sits between operand producers and result consumers on a valid/ready stream on both sides.
- Successor to the fixed 4-bit combinational parallel adder. Adds width/depth generality, throughput pipelining and backpressure.

---
 rtl/pipelined_adder_pkg.sv | 28 ++
 rtl/adder_chunk.sv | 31 +++
 rtl/pipelined_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// ============================================================================
//  pipelined_adder_pkg : shared constants, stage-count helper and stage record
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package pipelined_adder_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_CHUNK = 4;

   function automatic int calc_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Record layout for the default configuration; the top declares the same
   // layout sized by its own WIDTH.
   typedef struct packed {
      logic                     valid;
      logic                     carry;
      logic [DEFAULT_WIDTH-1:0] a_rem;
      logic [DEFAULT_WIDTH-1:0] b_rem;
      logic [DEFAULT_WIDTH-1:0] sum_acc;
   } stage_rec_t;

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
//  adder_chunk : combinational CHUNK-bit ripple-carry adder
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic c;

   always_comb begin
      s = '0;
      c = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
//  pipelined_adder : WIDTH-bit adder, one CHUNK-bit slice per pipeline stage,
//  valid/ready on both sides. Optional subtract mode: PIPELINED_ADDER_SUB_EN.
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);

   typedef struct packed {
      logic             valid;
      logic             carry;
`ifdef PIPELINED_ADDER_SUB_EN
      logic             sub;
`endif
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
      logic [WIDTH-1:0] sum_acc;
   } stage_t;

   if (CHUNK < 1 || WIDTH < CHUNK) begin : g_bad_size
      $error("pipelined_adder: need CHUNK >= 1 and WIDTH >= CHUNK");
   end
   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
   end

   stage_t stg [STAGES];
   logic   adv;

   // One global advance: a stall freezes every stage, bubbles included.
   assign out_valid = stg[STAGES-1].valid;
   assign sum       = stg[STAGES-1].sum_acc;
   assign cout      = stg[STAGES-1].carry;
   assign adv       = !out_valid | out_ready;
   assign in_ready  = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src;
      logic [WIDTH-1:0] b_src;
      logic [WIDTH-1:0] acc_src;
      logic             valid_src;
      logic             carry_src;
      logic [CHUNK-1:0] b_chunk;
      logic [CHUNK-1:0] s;
      logic             co;
      stage_t           d;
`ifdef PIPELINED_ADDER_SUB_EN
      logic             sub_src;
`endif

      if (k == 0) begin : g_head
         assign valid_src = in_valid;
         assign a_src     = a;
         assign b_src     = b;
         assign acc_src   = '0;
`ifdef PIPELINED_ADDER_SUB_EN
         // a - b - cin == a + ~b + ~cin
         assign sub_src   = sub;
         assign carry_src = cin ^ sub;
`else
         assign carry_src = cin;
`endif
      end else begin : g_body
         assign valid_src = stg[k-1].valid;
         assign a_src     = stg[k-1].a_rem;
         assign b_src     = stg[k-1].b_rem;
         assign acc_src   = stg[k-1].sum_acc;
         assign carry_src = stg[k-1].carry;
`ifdef PIPELINED_ADDER_SUB_EN
         assign sub_src   = stg[k-1].sub;
`endif
      end

`ifdef PIPELINED_ADDER_SUB_EN
      assign b_chunk = b_src[CHUNK-1:0] ^ {CHUNK{sub_src}};
`else
      assign b_chunk = b_src[CHUNK-1:0];
`endif

      adder_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a  (a_src[CHUNK-1:0]),
         .b  (b_chunk),
         .ci (carry_src),
         .s  (s),
         .co (co)
      );

      // Unconsumed operand bits shift down so the next slice always reads bit 0.
      always_comb begin
         d                           = '0;
         d.valid                     = valid_src;
         d.carry                     = co;
         d.a_rem                     = a_src >> CHUNK;
         d.b_rem                     = b_src >> CHUNK;
         d.sum_acc                   = acc_src;
         d.sum_acc[k*CHUNK +: CHUNK] = s;
`ifdef PIPELINED_ADDER_SUB_EN
         d.sub                       = sub_src;
`endif
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stg[k] <= '0;
         end else if (adv) begin
            stg[k] <= d;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
//  tb_pipelined_adder : directed self-checking bench, WIDTH=16 CHUNK=4
//  Revision 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipelined_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
`ifdef PIPELINED_ADDER_SUB_EN
   logic        sub;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [16:0] exp_q [$];

   always #5 clk = ~clk;

   pipelined_adder #(
      .WIDTH (16),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Every accepted result is compared, in order, against the queued expectation.
   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {31'd0, out_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", {15'd0, cout, sum}, {15'd0, e});
         end
      end
   end

   task automatic send(input logic [15:0] va, input logic [15:0] vb,
                       input logic vc, input logic [16:0] ex);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      cin      = vc;
      exp_q.push_back(ex);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("send_timeout", {31'd0, in_ready}, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_pending", exp_q.size(), 32'd0);
   endtask

   logic [15:0] s_a   [8] = '{16'h0000, 16'h0001, 16'h00FF, 16'h0F0F,
                              16'h8000, 16'hABCD, 16'h7FFF, 16'hFFFF};
   logic [15:0] s_b   [8] = '{16'h0000, 16'h0001, 16'h0001, 16'hF0F0,
                              16'h8001, 16'h1111, 16'h0001, 16'h0000};
   logic        s_c   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [16:0] s_exp [8] = '{17'h00000, 17'h00003, 17'h00100, 17'h0FFFF,
                              17'h10001, 17'h0BCDE, 17'h08000, 17'h10000};

   logic [15:0] p_a   [6] = '{16'h1000, 16'h2222, 16'hF000, 16'h0FFF, 16'h00AA, 16'h9999};
   logic [15:0] p_b   [6] = '{16'h0234, 16'h2222, 16'h1000, 16'h0FFF, 16'h0055, 16'h6666};
   logic        p_c   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [16:0] p_exp [6] = '{17'h01234, 17'h04445, 17'h10000, 17'h01FFE, 17'h00100, 17'h0FFFF};

   initial begin
      logic [15:0] held_sum;
      logic        held_cout;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
      sub       = 1'b0;
`endif
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum",       {16'd0, sum},       32'd0);
      check("rst_cout",      {31'd0, cout},      32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check("idle_in_ready",  {31'd0, in_ready},  32'd1);

      // Single op: result must appear after exactly four edges.
      send(16'h1234, 16'h4321, 1'b0, 17'h05555);
      for (int i = 0; i < 3; i++) begin
         check("lat_early", {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      check("lat_sum",   {16'd0, sum},       32'h5555);
      check("lat_cout",  {31'd0, cout},      32'd0);
      drain();

      send(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
      send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      drain();

      // Back-to-back stream: last result must be gone four edges after its acceptance.
      for (int i = 0; i < 8; i++) send(s_a[i], s_b[i], s_c[i], s_exp[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("stream_consecutive", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
      drain();

      // Backpressure: stall while the first result is presented.
      for (int i = 0; i < 4; i++) send(p_a[i], p_b[i], p_c[i], p_exp[i]);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = p_a[4];
      b         = p_b[4];
      cin       = p_c[4];
      #1;
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      held_sum  = sum;
      held_cout = cout;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("stall_hold_sum",  {16'd0, sum},       {16'd0, held_sum});
         check("stall_hold_cout", {31'd0, cout},      {31'd0, held_cout});
         check("stall_hold_vld",  {31'd0, out_valid}, 32'd1);
         check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      for (int i = 4; i < 6; i++) send(p_a[i], p_b[i], p_c[i], p_exp[i]);
      drain();

      // Reset pulse between edges while three ops are in flight.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = 16'h0101 * 16'(i + 1);
         b        = 16'h1010;
         cin      = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      end
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      send(16'h0F00, 16'h00F0, 1'b1, 17'h00FF1);
      drain();

`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'b1;
      send(16'h0005, 16'h0007, 1'b0, 17'h0FFFE);
      send(16'h0007, 16'h0005, 1'b0, 17'h10002);
      send(16'h0007, 16'h0005, 1'b1, 17'h10001);
      sub = 1'b0;
      send(16'h0007, 16'h0005, 1'b1, 17'h0000D);
      drain();
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
